// File: rtl/seven_segment_pkg.sv
// Shared definitions for the multiplexed seven-segment driver:
// the hex font, the all-off segment pattern and the pin polarity helper.
package seven_segment_pkg;

   // Logical (1 = lit) segment pattern of a dark digit.
   localparam logic [6:0] blank_segs = 7'b0000000;

   // Hex digit to logical segments, bit 6 = a down to bit 0 = g.
   function automatic logic [6:0] hex_font(input logic [3:0] hex);
      logic [6:0] segs;
      case (hex)
         4'h0:    segs = 7'b1111110;
         4'h1:    segs = 7'b0110000;
         4'h2:    segs = 7'b1101101;
         4'h3:    segs = 7'b1111001;
         4'h4:    segs = 7'b0110011;
         4'h5:    segs = 7'b1011011;
         4'h6:    segs = 7'b1011111;
         4'h7:    segs = 7'b1110000;
         4'h8:    segs = 7'b1111111;
         4'h9:    segs = 7'b1111011;
         4'hA:    segs = 7'b1110111;
         4'hB:    segs = 7'b0011111;
         4'hC:    segs = 7'b1001110;
         4'hD:    segs = 7'b0111101;
         4'hE:    segs = 7'b1001111;
         default: segs = 7'b1000111;
      endcase
      return segs;
   endfunction

   // Converts logical segments to pin levels for the board's wiring.
   function automatic logic [6:0] apply_seg_polarity(input logic [6:0] lit, input logic active_low);
      return active_low ? ~lit : lit;
   endfunction

endpackage

// File: rtl/seven_segment_timebase.sv
// Scan timebase: slot prescaler, digit index, frame counter and blink phase.
// frame_end marks the last cycle of a frame (snapshot moment); frame_begin
// follows it by one cycle and is only ever raised by a real frame wrap,
// so the short frame straight after reset has no frame_begin.
module seven_segment_timebase #(
   parameter int n_digits     = 8,
   parameter int refresh_div  = 1024,
   parameter int blink_frames = 64,
   localparam int pcnt_w      = $clog2(refresh_div),
   localparam int idx_w       = $clog2(n_digits),
   localparam int fcnt_w      = $clog2(blink_frames + 1)
) (
   input  logic              clk,
   input  logic              reset,
   output logic [pcnt_w-1:0] pcnt,
   output logic [idx_w-1:0]  idx,
   output logic              blink_phase,
   output logic              frame_end,
   output logic              frame_begin
);

   localparam logic [pcnt_w-1:0] pcnt_last = pcnt_w'(refresh_div - 1);
   localparam logic [idx_w-1:0]  idx_last  = idx_w'(n_digits - 1);
   localparam logic [fcnt_w-1:0] fcnt_last = fcnt_w'(blink_frames - 1);

   logic [fcnt_w-1:0] fcnt;
   logic              slot_end;

   assign slot_end  = (pcnt == pcnt_last);
   assign frame_end = slot_end && (idx == idx_last);

   // Prescaler counts through one digit slot, then the scan moves to the next digit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt <= '0;
         idx  <= '0;
      end else if (slot_end) begin
         pcnt <= '0;
         idx  <= (idx == idx_last) ? '0 : idx + idx_w'(1);
      end else begin
         pcnt <= pcnt + pcnt_w'(1);
      end
   end

   // Frame counter flips the blink phase every blink_frames frames.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fcnt        <= '0;
         blink_phase <= 1'b0;
      end else if (frame_end) begin
         if (fcnt == fcnt_last) begin
            fcnt        <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            fcnt <= fcnt + fcnt_w'(1);
         end
      end
   end

   // Marks the first cycle of a frame that followed a wrap from the last digit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) frame_begin <= 1'b0;
      else       frame_begin <= frame_end;
   end

endmodule

// File: rtl/seven_segment_mux.sv
// Multiplexed seven-segment driver. Frame data is snapshotted once per frame
// so a whole scan shows one coherent value; each digit slot is then gated by
// brightness PWM, blinking and leading-zero blanking before the output regs.
module seven_segment_mux
   import seven_segment_pkg::*;
#(
   parameter int n_digits         = 8,
   parameter int refresh_div      = 1024,
   parameter int brightness_w     = 3,
   parameter int blink_frames     = 64,
   parameter bit anode_active_low = 1'b1,
   parameter bit seg_active_low   = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*n_digits-1:0]   num,
   input  logic [n_digits-1:0]     dots,
   input  logic [n_digits-1:0]     blink_mask,
   input  logic                    blank_lz,
   input  logic [brightness_w-1:0] brightness,
   output logic [6:0]              abcdefg,
   output logic                    dot,
   output logic [n_digits-1:0]     anodes,
   output logic                    frame_start
);

   localparam int pcnt_w = $clog2(refresh_div);
   localparam int idx_w  = $clog2(n_digits);
   localparam logic [pcnt_w-1:0] phase_len = pcnt_w'(refresh_div >> brightness_w);

   logic [pcnt_w-1:0]       pcnt;
   logic [idx_w-1:0]        idx;
   logic                    blink_phase;
   logic                    frame_end;
   logic                    frame_begin;

   logic [4*n_digits-1:0]   snap_num;
   logic [n_digits-1:0]     snap_dots;
   logic [n_digits-1:0]     snap_mask;
   logic                    snap_blz;
   logic [brightness_w-1:0] snap_bright;

   logic [3:0]              digit_vals [n_digits];
   logic [n_digits-1:0]     lz_blank;
   logic                    zero_run;
   logic                    on_phase;
   logic                    blink_hidden;
   logic                    lz_hidden;
   logic                    show;
   logic [6:0]              seg_lit;
   logic                    dot_lit;
   logic [n_digits-1:0]     sel;

   seven_segment_timebase #(
      .n_digits    (n_digits),
      .refresh_div (refresh_div),
      .blink_frames(blink_frames)
   ) u_timebase (
      .clk        (clk),
      .reset      (reset),
      .pcnt       (pcnt),
      .idx        (idx),
      .blink_phase(blink_phase),
      .frame_end  (frame_end),
      .frame_begin(frame_begin)
   );

   // Captures all user inputs at the end of each frame for the next one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_num    <= '0;
         snap_dots   <= '0;
         snap_mask   <= '0;
         snap_blz    <= 1'b0;
         snap_bright <= '0;
      end else if (frame_end) begin
         snap_num    <= num;
         snap_dots   <= dots;
         snap_mask   <= blink_mask;
         snap_blz    <= blank_lz;
         snap_bright <= brightness;
      end
   end

   // Splits the snapshot into per-digit nibbles for indexed selection.
   always_comb begin
      for (int i = 0; i < n_digits; i++) begin
         digit_vals[i] = snap_num[4*i +: 4];
      end
   end

   // A digit is a leading zero when it and every digit above it are zero; digit 0 is exempt.
   always_comb begin
      lz_blank = '0;
      zero_run = snap_blz;
      for (int i = n_digits - 1; i >= 1; i--) begin
         zero_run    = zero_run && (snap_num[4*i +: 4] == 4'h0);
         lz_blank[i] = zero_run;
      end
   end

   // Decides what the current slot shows; a leading-zero digit keeps its dot.
   always_comb begin
      on_phase     = (pcnt / phase_len) <= pcnt_w'(snap_bright);
      blink_hidden = blink_phase && snap_mask[idx];
      lz_hidden    = lz_blank[idx];
      show         = on_phase && !blink_hidden && (!lz_hidden || snap_dots[idx]);
      seg_lit      = (show && !lz_hidden) ? hex_font(digit_vals[idx]) : blank_segs;
      dot_lit      = show && snap_dots[idx];
      sel          = '0;
      sel[idx]     = show;
   end

   // Registers the pins with board polarity applied; reset forces everything dark.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         anodes      <= {n_digits{anode_active_low}};
         abcdefg     <= apply_seg_polarity(blank_segs, seg_active_low);
         dot         <= seg_active_low;
         frame_start <= 1'b0;
      end else begin
         anodes      <= sel ^ {n_digits{anode_active_low}};
         abcdefg     <= apply_seg_polarity(seg_lit, seg_active_low);
         dot         <= dot_lit ^ seg_active_low;
         frame_start <= frame_begin;
      end
   end

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed bench for seven_segment_mux with 4 digits, 8-cycle slots,
// 2-bit brightness, 2-frame blink half-period and active-low pins.
module tb_seven_segment_mux;

   logic        clk;
   logic        reset;
   logic [15:0] num;
   logic [3:0]  dots;
   logic [3:0]  blink_mask;
   logic        blank_lz;
   logic [1:0]  brightness;
   logic [6:0]  abcdefg;
   logic        dot;
   logic [3:0]  anodes;
   logic        frame_start;

   int compared   = 0;
   int mismatched = 0;

   // Active-low segment patterns worked out by hand from the hex font.
   localparam logic [6:0] S0   = 7'b0000001;
   localparam logic [6:0] S1   = 7'b1001111;
   localparam logic [6:0] S2   = 7'b0010010;
   localparam logic [6:0] S3   = 7'b0000110;
   localparam logic [6:0] S4   = 7'b1001100;
   localparam logic [6:0] S5   = 7'b0100100;
   localparam logic [6:0] SA   = 7'b0001000;
   localparam logic [6:0] SC   = 7'b0110001;
   localparam logic [6:0] SF   = 7'b0111000;
   localparam logic [6:0] SOFF = 7'b1111111;

   seven_segment_mux #(
      .n_digits        (4),
      .refresh_div     (8),
      .brightness_w    (2),
      .blink_frames    (2),
      .anode_active_low(1'b1),
      .seg_active_low  (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .num        (num),
      .dots       (dots),
      .blink_mask (blink_mask),
      .blank_lz   (blank_lz),
      .brightness (brightness),
      .abcdefg    (abcdefg),
      .dot        (dot),
      .anodes     (anodes),
      .frame_start(frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] n, input logic [3:0] d, input logic [3:0] m,
                                input logic lz, input logic [1:0] b);
      num        = n;
      dots       = d;
      blink_mask = m;
      blank_lz   = lz;
      brightness = b;
   endtask

   // Called at the negedge after the frame's first output edge; checks all 32
   // cycles as {frame_start, anodes, abcdefg, dot}. segs/dts are active-low
   // per digit {d3,d2,d1,d0}, ons says whether the digit's anode may assert,
   // onc is how many cycles of each slot are lit.
   task automatic checkFrame(input string tag, input logic [27:0] segs, input logic [3:0] dts,
                             input logic [3:0] ons, input int onc, input logic fs0);
      for (int j = 0; j < 32; j++) begin
         int          d;
         int          p;
         logic        lit;
         logic [12:0] expv;
         d    = j / 8;
         p    = j % 8;
         lit  = ons[d] && (p < onc);
         expv = {(j == 0) ? fs0 : 1'b0,
                 lit ? ~(4'b0001 << d) : 4'b1111,
                 lit ? segs[7*d +: 7] : SOFF,
                 lit ? dts[d] : 1'b1};
         checkOutput($sformatf("%s_j%0d", tag, j), 32'({frame_start, anodes, abcdefg, dot}), 32'(expv));
         @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd3);
      repeat (3) @(negedge clk);
      checkOutput("reset_state", 32'({frame_start, anodes, abcdefg, dot}), 32'({1'b0, 4'hF, SOFF, 1'b1}));

      $display("[TB] first frame after reset shows snapshot zero");
      reset = 1'b0;
      @(negedge clk);
      checkFrame("frame0", {S0, S0, S0, S0}, 4'b1111, 4'b1111, 2, 1'b0);

      $display("[TB] full brightness 1234, inputs changed mid-frame");
      fork
         checkFrame("frame1", {S1, S2, S3, S4}, 4'b1111, 4'b1111, 8, 1'b1);
         begin
            repeat (12) @(negedge clk);
            applyStimulus(16'h0050, 4'b1000, 4'b0000, 1'b1, 2'd1);
         end
      join

      $display("[TB] leading-zero blanking, dot on blanked digit, half brightness");
      applyStimulus(16'h1234, 4'b0000, 4'b0001, 1'b0, 2'd3);
      checkFrame("frame2_lz", {SOFF, SOFF, S5, S0}, 4'b0111, 4'b1011, 4, 1'b1);

      $display("[TB] blinking digit 0");
      checkFrame("frame3_blinkoff", {S1, S2, S3, S4}, 4'b1111, 4'b1110, 8, 1'b1);
      checkFrame("frame4_blinkon",  {S1, S2, S3, S4}, 4'b1111, 4'b1111, 8, 1'b1);
      checkFrame("frame5_blinkon",  {S1, S2, S3, S4}, 4'b1111, 4'b1111, 8, 1'b1);
      checkFrame("frame6_blinkoff", {S1, S2, S3, S4}, 4'b1111, 4'b1110, 8, 1'b1);

      $display("[TB] reset in the middle of a slot");
      repeat (9) @(negedge clk);
      checkOutput("pre_reset", 32'({frame_start, anodes, abcdefg, dot}), 32'({1'b0, 4'b1101, S3, 1'b1}));
      #2 reset = 1'b1;
      #1 checkOutput("midslot_reset", 32'({frame_start, anodes, abcdefg, dot}), 32'({1'b0, 4'hF, SOFF, 1'b1}));
      applyStimulus(16'hF0CA, 4'b0101, 4'b0001, 1'b0, 2'd2);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkFrame("restart0", {S0, S0, S0, S0}, 4'b1111, 4'b1111, 2, 1'b0);
      checkFrame("restart1", {SF, S0, SC, SA}, 4'b1010, 4'b1111, 6, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/seven_segment_mux.md
# seven_segment_mux

Parametrised multiplexed seven-segment driver for board-level status and debug displays. It captures a hex value and decimal points once per frame, scans the digits with a built-in refresh prescaler, and adds brightness PWM, per-digit blinking and leading-zero blanking. It sits between user logic and the board display pins; pin polarity is set by parameters.

## Interface
- `n_digits`, 8, number of digits/anodes scanned (≥2)
- `refresh_div`, 1024, clock cycles per digit slot; multiple of 2^`brightness_w`, ≥ 2^`brightness_w`
- `brightness_w`, 3, width of the brightness input; a slot has 2^`brightness_w` phases
- `blink_frames`, 64, frames per blink half-period (≥1)
- `anode_active_low`, 1, 1 = anode asserted by driving 0
- `seg_active_low`, 1, 1 = segment/dot lit by driving 0

Ports:
- `clk` in 1: clock
- `reset` in 1: reset, asynchronous, active-high
- `num` in 4*`n_digits`: hex digits, digit i = `num[4i+3:4i]`, digit 0 rightmost
- `dots` in `n_digits`: decimal point per digit
- `blink_mask` in `n_digits`: 1 = digit blinks
- `blank_lz` in 1: enable leading-zero blanking
- `brightness` in `brightness_w`: on-phases per slot minus one
- `abcdefg` out 7: segments, bit 6 = a … bit 0 = g, polarity per `seg_active_low`
- `dot` out 1: decimal point, polarity per `seg_active_low`
- `anodes` out `n_digits`: one-hot (in asserted polarity) digit select
- `frame_start` out 1: one-cycle pulse when digit 0's slot begins

## Operation
- Prescaler `pcnt` counts 0..`refresh_div`-1 and wraps. At terminal count, digit index `idx` advances; `n_digits`-1 wraps to 0.
- Frame = `n_digits`*`refresh_div` cycles. Snapshot: at terminal count with `idx`=`n_digits`-1, `num`, `dots`, `blink_mask`, `blank_lz` and `brightness` are registered. The next frame uses only the snapshot, so all frame data is coherent.
- Phase = top `brightness_w` bits of `pcnt` scaled to the slot: phase = `pcnt` / (`refresh_div`/2^`brightness_w`). A digit is driven only while phase ≤ snapshot `brightness`, so the maximum value gives 100 % duty.
- Blink: a frame counter counts 0..`blink_frames`-1. At each wrap, `blink_phase` toggles. While `blink_phase`=1, digits with a mask bit set are blanked (segments and dot).
- Leading-zero blanking (snapshot `blank_lz`=1): digit i is blanked if all digits i..`n_digits`-1 are 0. Digit 0 is never blanked by this rule, and its dot stays independent of it. A blanked digit with its dot set shows only the dot.
- Blanked or off-phase digit: anodes all deasserted, segments off, dot off.
- Font: standard hex 0-F (0 lights a-f, 1 = b,c, … F = a,e,f,g). The table is in logical (1 = lit) form; polarity is applied at the output register.

## Timing
- All outputs are registered and reflect the state of `pcnt`/`idx` one cycle earlier.
- Reset (async) sets: `pcnt`=0, `idx`=0, frame counter 0, `blink_phase`=0, snapshot 0. Outputs go immediately to all anodes deasserted, all segments/dot off, and `frame_start`=0.
- The first frame after reset displays snapshot 0, which is digit 0 = "0" at brightness 0. New inputs appear from the following frame.
- `frame_start` is high in the first cycle that digit 0's anode can be asserted, i.e. one cycle after `pcnt` wraps into `idx`=0.
- Inputs may change at any time; changes are seen only at the next snapshot. A reset mid-frame discards the frame and restarts at digit 0.
- There is no anode overlap: at most one anode is asserted in any cycle, including on `idx` transitions.

## Structure
- Package `seven_segment_pkg`:
  - font function (hex to logical abcdefg)
  - blank-pattern constant
  - polarity-application helper
- Sub-module `seven_segment_timebase`: prescaler, digit index, frame counter, blink phase, terminal-count/snapshot strobes.
- Top level: snapshot registers, leading-zero logic, digit select, phase gating, output registers.

## Test plan
Default bench parameters: `n_digits`=4, `refresh_div`=8, `brightness_w`=2, `blink_frames`=2, active-low pins.
- Reset held, then released -> anodes=4'b1111, abcdefg=7'b1111111, dot=1. `frame_start` first pulses 33 cycles after release; snapshot digit 0 shows 7'b0000001 for 2 cycles (brightness 0).
- `num`=16'h1234, `brightness`=3 -> from frame 2, each digit is held 8 cycles. Anodes 1110/1101/1011/0111 show 4, 3, 2, 1 (7'b1001100, 0000110, 0010010, 1001111); never two anodes low.
- `brightness`=1 -> each anode low for exactly 4 of 8 slot cycles, starting at slot start.
- `num`=16'h0050, `blank_lz`=1, `dots`=4'b1000 -> digit 0 = "0", digit 1 = "5", digit 2 blank, digit 3 shows only the dot.
- `blink_mask`=4'b0001 -> digit 0 is visible for 2 frames and blanked for 2 frames, alternately; the other digits are unaffected.
- `num` changed mid-frame -> no change within the current frame; the new value appears from the next `frame_start`. Reset asserted mid-slot -> outputs blank in the same cycle.
